// File: rtl/debug_uart_tx.sv
// Debug link transmitter: snapshots seven CPU debug ports and sends them as
// one 9-byte 8N1 burst (SYNC, port1..port7, checksum), LSB first.
module debug_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      byte_q, byte_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      snap_q [7];
  logic [7:0]      csum_q;
  logic [7:0]      port_w [7];
  logic [7:0]      csum_w;
  logic [7:0]      byte_val;
  logic            accept;

  // Gather the ports into an array and form their 8-bit wrap-around sum.
  always_comb begin
    port_w[0] = debug_port1;
    port_w[1] = debug_port2;
    port_w[2] = debug_port3;
    port_w[3] = debug_port4;
    port_w[4] = debug_port5;
    port_w[5] = debug_port6;
    port_w[6] = debug_port7;
    csum_w    = '0;
    for (int i = 0; i < 7; i++) csum_w = csum_w + port_w[i];
  end

  // Byte that will be on the line for the next cycle's byte index.
  always_comb begin
    byte_val = SYNC_BYTE;
    case (byte_d)
      4'd1:    byte_val = snap_q[0];
      4'd2:    byte_val = snap_q[1];
      4'd3:    byte_val = snap_q[2];
      4'd4:    byte_val = snap_q[3];
      4'd5:    byte_val = snap_q[4];
      4'd6:    byte_val = snap_q[5];
      4'd7:    byte_val = snap_q[6];
      4'd8:    byte_val = csum_q;
      default: byte_val = SYNC_BYTE;
    endcase
  end

  // Next-state logic: bit/byte sequencing and registered output values.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (send) begin
          accept  = 1'b1;
          state_d = S_START;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
          byte_d  = '0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_MAX;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          if (byte_q == 4'd8) begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
            byte_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_START;
            baud_d  = BAUD_MAX;
            byte_d  = byte_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_val[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame snapshot, captured only on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 7; i++) snap_q[i] <= '0;
      csum_q <= '0;
    end else if (accept) begin
      for (int i = 0; i < 7; i++) snap_q[i] <= port_w[i];
      csum_q <= csum_w;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
